rb_seq_shifter: RTL



---
 rtl/rb_seq_shifter_if.sv | 21 ++
 rtl/rb_seq_shifter.sv | 96 +++++++++
 2 files changed

// File: rtl/rb_seq_shifter_if.sv
// Handshake and operand bundle for the sequential right shifter.
// master = ALU controller side, slave = shifter side.
interface rb_seq_shifter_if;
  logic        start;
  logic [16:1] a;
  logic [4:1]  shift;
  logic        arith;
  logic [16:1] out;
  logic        busy;
  logic        done;

  modport master (
    output start, a, shift, arith,
    input  out, busy, done
  );

  modport slave (
    input  start, a, shift, arith,
    output out, busy, done
  );
endinterface

// File: rtl/rb_seq_shifter.sv
// 16-bit logical/arithmetic right shifter, one shift-amount bit per cycle; start sampled only in IDLE.
// Latency 5 cycles start->done (RBSHIFTER_EARLY_EXIT_EN: 2..5 by highest set shift bit); start while busy is dropped.
module rb_seq_shifter (
  input  logic            clk,
  input  logic            reset,
  rb_seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [16:1] acc;
  logic [4:1]  amt;
  logic        fill;
  logic [1:0]  stage;
  logic        busy_r;
  logic        done_r;

  logic [16:1] acc_next;
  logic        last_stage;

  assign bus.out  = acc;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // Stage k shifts by 2^k positions when the matching amount bit is set.
  always_comb begin
    acc_next = acc;
    case (stage)
      2'd0: if (amt[1]) acc_next = {fill, acc[16:2]};
      2'd1: if (amt[2]) acc_next = {{2{fill}}, acc[16:3]};
      2'd2: if (amt[3]) acc_next = {{4{fill}}, acc[16:5]};
      default: if (amt[4]) acc_next = {{8{fill}}, acc[16:9]};
    endcase
  end

  always_comb begin
`ifdef RBSHIFTER_EARLY_EXIT_EN
    // Stop once no higher amount bits remain to be applied.
    case (stage)
      2'd0:    last_stage = (amt[4:2] == 3'd0);
      2'd1:    last_stage = (amt[4:3] == 2'd0);
      2'd2:    last_stage = !amt[4];
      default: last_stage = 1'b1;
    endcase
`else
    last_stage = (stage == 2'd3);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      amt    <= '0;
      fill   <= 1'b0;
      stage  <= 2'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            acc    <= bus.a;
            amt    <= bus.shift;
            fill   <= bus.arith & bus.a[16];
            stage  <= 2'd0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          if (last_stage) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            stage <= stage + 2'd1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
